// File: rtl/mult_pkg.sv
// Shared definitions for the approximate multiplier datapath:
// controller states, default widths and parameter helpers.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_CHUNK = 4;

    // Number of CHUNK-wide slices needed to cover a W-bit row.
    function automatic int n_chunks(input int w, input int chunk);
        return w / chunk;
    endfunction

    // True when a row of width w splits into whole chunks of width chunk.
    function automatic bit chunk_fit_ok(input int w, input int chunk);
        return (chunk >= 1) && (chunk <= w) && ((w % chunk) == 0);
    endfunction

endpackage

// File: rtl/cs_chunk_add.sv
// CHUNK-bit ripple-carry adder used by the sequential carry-propagate stage,
// assembled from single-bit full-adder cells.

// Single-bit full adder cell.
module cs_full_add (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

module cs_chunk_add import mult_pkg::*; #(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar b = 0; b < CHUNK; b++) begin : g_bit
        cs_full_add u_fa (
            .i_a  (i_a[b]),
            .i_b  (i_b[b]),
            .i_ci (w_carry[b]),
            .o_s  (o_s[b]),
            .o_co (w_carry[b+1])
        );
    end

    assign o_cout = w_carry[CHUNK];

endmodule

// File: rtl/cs_resolve_seq.sv
// Final carry-propagate stage: folds the redundant sum/carry rows from the
// compressor tree into one exact binary product, CHUNK bits per clock.
module cs_resolve_seq import mult_pkg::*; #(
    parameter int W     = DEF_W,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_result,
    output logic         busy
);

    localparam int N  = n_chunks(W, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    if (!chunk_fit_ok(W, CHUNK)) begin : g_paramCheck
        $error("cs_resolve_seq: W must be a positive multiple of CHUNK");
    end

    state_t          r_state;
    logic [W-1:0]    r_opSum;
    logic [W-1:0]    r_opCarry;
    logic [IW-1:0]   r_idx;
    logic            r_runCarry;
    logic [W:0]      r_result;
    logic            r_outValid;

    logic [CHUNK-1:0] w_chunkA;
    logic [CHUNK-1:0] w_chunkB;
    logic [CHUNK-1:0] w_chunkS;
    logic             w_chunkCout;

    // Steer the slice selected by the chunk index onto the single adder.
    always_comb begin
        w_chunkA = '0;
        w_chunkB = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
                w_chunkA = r_opSum[k*CHUNK +: CHUNK];
                w_chunkB = r_opCarry[k*CHUNK +: CHUNK];
            end
        end
    end

    cs_chunk_add #(.CHUNK(CHUNK)) u_chunkAdd (
        .i_a    (w_chunkA),
        .i_b    (w_chunkB),
        .i_cin  (r_runCarry),
        .o_s    (w_chunkS),
        .o_cout (w_chunkCout)
    );

    // Controller and datapath: accept in IDLE, ripple one chunk per cycle in ADD, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_opSum    <= '0;
            r_opCarry  <= '0;
            r_idx      <= '0;
            r_runCarry <= 1'b0;
            r_result   <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opSum    <= in_sum;
                        r_opCarry  <= in_carry;
                        r_idx      <= '0;
                        r_runCarry <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    for (int k = 0; k < N; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_result[k*CHUNK +: CHUNK] <= w_chunkS;
                        end
                    end
                    r_runCarry <= w_chunkCout;
                    if (r_idx == LAST_IDX) begin
                        r_result[W] <= w_chunkCout;
                        r_outValid  <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE) && !rst;
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_outValid;
    assign out_result = r_result;

endmodule

// File: tb/tb_cs_resolve_seq.sv
// Directed self-checking bench for cs_resolve_seq: default CHUNK=4 instance
// plus CHUNK=1/8/16 instances for the parameter sweep.
module tb_cs_resolve_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] inSum;
    logic [15:0] inCarry;
    logic        outValid;
    logic        outReady;
    logic [16:0] outResult;
    logic        busy;

    logic        swInValid  [3];
    logic        swInReady  [3];
    logic [15:0] swSum      [3];
    logic [15:0] swCarry    [3];
    logic        swOutValid [3];
    logic        swOutReady [3];
    logic [16:0] swResult   [3];
    logic        swBusy     [3];

    int total = 0;
    int bad   = 0;

    // Free-running 10 ns clock shared by every instance.
    always #5 clk = ~clk;

    cs_resolve_seq #(.W(16), .CHUNK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_sum     (inSum),
        .in_carry   (inCarry),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .busy       (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        cs_resolve_seq #(.W(16), .CHUNK((g == 0) ? 1 : ((g == 1) ? 8 : 16))) u_sw (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (swInValid[g]),
            .in_ready   (swInReady[g]),
            .in_sum     (swSum[g]),
            .in_carry   (swCarry[g]),
            .out_valid  (swOutValid[g]),
            .out_ready  (swOutReady[g]),
            .out_result (swResult[g]),
            .busy       (swBusy[g])
        );
    end

    function automatic int sweepChunk(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 8 : 16);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one row pair on the main instance at a falling edge.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] c);
        @(negedge clk);
        inSum   = s;
        inCarry = c;
        inValid = 1'b1;
    endtask

    // Called just before the accepting edge; counts edges until out_valid is seen.
    task automatic waitResult(input string tag, input logic [16:0] exp, input int expLat);
        int lat  = 0;
        bit seen = 1'b0;
        @(posedge clk);
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            inValid = 1'b0;
            seen    = outValid;
        end
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, outResult, exp);
        checkOutput({tag, " in_ready low"}, inReady, 1'b0);
        checkOutput({tag, " busy high"}, busy, 1'b1);
    endtask

    task automatic finishHandshake(input string tag, input logic [16:0] exp);
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " out_valid drop"}, outValid, 1'b0);
        checkOutput({tag, " in_ready back"}, inReady, 1'b1);
        checkOutput({tag, " busy idle"}, busy, 1'b0);
        checkOutput({tag, " result kept"}, outResult, exp);
    endtask

    task automatic sweepOp(input int g, input logic [15:0] s, input logic [15:0] c);
        int lat    = 0;
        bit seen   = 1'b0;
        int expLat = 16 / sweepChunk(g);
        logic [16:0] expRes;
        string tag;
        expRes = {1'b0, s} + {1'b0, c};
        tag    = $sformatf("sw%0d", sweepChunk(g));
        @(negedge clk);
        swSum[g]     = s;
        swCarry[g]   = c;
        swInValid[g] = 1'b1;
        #1;
        checkOutput({tag, " in_ready"}, swInReady[g], 1'b1);
        @(posedge clk);
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            swInValid[g] = 1'b0;
            seen         = swOutValid[g];
        end
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, swResult[g], expRes);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " out_valid drop"}, swOutValid[g], 1'b0);
    endtask

    // Hard stop in case something above never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        logic [15:0] opS [3];
        logic [15:0] opC [3];
        logic [16:0] res [3];
        int          accEdge [3];
        int          edgeN;
        int          nAcc;
        int          nRes;
        int          nextOp;
        int          validSeen;
        bit          load;

        rst      = 1'b1;
        inValid  = 1'b0;
        inSum    = '0;
        inCarry  = '0;
        outReady = 1'b1;
        for (int g = 0; g < 3; g++) begin
            swInValid[g]  = 1'b0;
            swSum[g]      = '0;
            swCarry[g]    = '0;
            swOutReady[g] = 1'b1;
        end

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset out_result", outResult, 17'h0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset in_ready gated", inReady, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-reset in_ready", inReady, 1'b1);

        $display("[TB] basic add");
        applyStimulus(16'h1234, 16'h4321);
        #1;
        checkOutput("t1 in_ready", inReady, 1'b1);
        waitResult("t1", 17'h05555, 4);
        finishHandshake("t1", 17'h05555);

        $display("[TB] carry ripple");
        applyStimulus(16'hFFFF, 16'h0001);
        waitResult("ripple1", 17'h10000, 4);
        finishHandshake("ripple1", 17'h10000);
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitResult("ripple2", 17'h1FFFE, 4);
        finishHandshake("ripple2", 17'h1FFFE);

        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(16'h00F0, 16'h0F00);
        waitResult("bp", 17'h00FF0, 4);
        inValid = 1'b1;
        inSum   = 16'h1111;
        inCarry = 16'h1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp hold valid %0d", i), outValid, 1'b1);
            checkOutput($sformatf("bp hold result %0d", i), outResult, 17'h00FF0);
            checkOutput($sformatf("bp hold in_ready %0d", i), inReady, 1'b0);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp released valid", outValid, 1'b0);
        checkOutput("bp released in_ready", inReady, 1'b1);
        checkOutput("bp released result", outResult, 17'h00FF0);
        waitResult("bp second", 17'h02222, 4);
        finishHandshake("bp second", 17'h02222);

        $display("[TB] back-to-back");
        opS[0] = 16'h0000; opC[0] = 16'h0000;
        opS[1] = 16'h8000; opC[1] = 16'h8000;
        opS[2] = 16'hAAAA; opC[2] = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            accEdge[i] = 0;
            res[i]     = 'x;
        end
        edgeN  = 0;
        nAcc   = 0;
        nRes   = 0;
        load   = 1'b0;
        @(negedge clk);
        inSum   = opS[0];
        inCarry = opC[0];
        inValid = 1'b1;
        nextOp  = 1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            if (load) begin
                load = 1'b0;
                if (nextOp < 3) begin
                    inSum   = opS[nextOp];
                    inCarry = opC[nextOp];
                    nextOp++;
                end else begin
                    inValid = 1'b0;
                end
            end
            #1;
            if (outValid && nRes < 3) begin
                res[nRes] = outResult;
                nRes++;
            end
            if (inReady && inValid && nAcc < 3) begin
                accEdge[nAcc] = edgeN + 1;
                nAcc++;
                load = 1'b1;
            end
            @(posedge clk);
            edgeN++;
            @(negedge clk);
        end
        checkOutput("b2b accepts", nAcc, 3);
        checkOutput("b2b results", nRes, 3);
        checkOutput("b2b res0", res[0], 17'h00000);
        checkOutput("b2b res1", res[1], 17'h10000);
        checkOutput("b2b res2", res[2], 17'h0FFFF);
        checkOutput("b2b gap01", accEdge[1] - accEdge[0], 6);
        checkOutput("b2b gap12", accEdge[2] - accEdge[1], 6);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h1234, 16'h4321);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort in ADD", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort out_valid", outValid, 1'b0);
        checkOutput("abort out_result", outResult, 17'h0);
        checkOutput("abort in_ready", inReady, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (outValid) validSeen++;
        end
        checkOutput("abort no result", validSeen, 0);

        $display("[TB] parameter sweep");
        for (int g = 0; g < 3; g++) begin
            for (int v = 0; v < 3; v++) begin
                sweepOp(g, 16'($urandom), 16'($urandom));
            end
            sweepOp(g, 16'hFFFF, 16'hFFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
